// File: rtl/sram_responder_pkg.sv
// Shared types and constants for the SLC-3 SRAM responder: FSM states,
// the preload program and byte-lane indices.
package sram_responder_pkg;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_RD_WAIT,
        ST_RD_DRIVE
    } state_e;

    localparam int unsigned PROG_LEN = 3;

    // PROGRAM[0] is the word loaded at address 0
    localparam logic [PROG_LEN-1:0][15:0] PROGRAM = {16'h0FFE, 16'h1021, 16'h5020};

    localparam int unsigned LANE_HI    = 1;
    localparam int unsigned LANE_LO    = 0;
    localparam logic [1:0]  LANES_NONE = 2'b00;
    localparam logic [1:0]  LANES_ALL  = 2'b11;

    // Words past the end of the program shift out to zero
    function automatic logic [15:0] program_word(input int unsigned idx);
        logic [PROG_LEN*16-1:0] words;
        words = PROGRAM >> (idx * 16);
        return words[15:0];
    endfunction

endpackage

// File: rtl/sram_responder_if.sv
// Processor-to-SRAM control/address bus; the shared Data bus is a separate inout.
interface sram_responder_if;

    logic [19:0] ADDR;
    logic        Mem_CE;
    logic        Mem_UB;
    logic        Mem_LB;
    logic        Mem_OE;
    logic        Mem_WE;
    logic        Ready;
    logic        Data_drive;

    modport master (
        output ADDR, Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE,
        input  Ready, Data_drive
    );

    modport slave (
        input  ADDR, Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE,
        output Ready, Data_drive
    );

endinterface

// File: rtl/sram_responder_bytelane_ram.sv
// Single-port synchronous word RAM with per-byte write enables and a
// registered (read-first) output.
module bytelane_ram
    import sram_responder_pkg::*;
#(
    parameter int unsigned AW = 10
) (
    input  logic          clk_i,
    input  logic [1:0]    we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [15:0]   wdata_i,
    output logic [15:0]   rdata_o
);

    logic [15:0] mem_q [0:(1<<AW)-1];
    logic [15:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i[LANE_HI]) begin
            mem_q[addr_i][15:8] <= wdata_i[15:8];
        end
        if (we_i[LANE_LO]) begin
            mem_q[addr_i][7:0] <= wdata_i[7:0];
        end
        rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sram_responder.sv
// Device end of the SLC-3 external SRAM bus: preloads a program after reset,
// then serves byte-lane writes and wait-stated reads from on-chip RAM.
module sram_responder
    import sram_responder_pkg::*;
#(
    parameter int unsigned ADDR_BITS    = 10,
    parameter int unsigned READ_LATENCY = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    sram_responder_if.slave   bus,
    inout  wire  [15:0]       Data
);

    localparam logic [3:0] CNT_RELOAD = 4'(READ_LATENCY - 1);
    localparam state_e     RELOAD_ST  = (READ_LATENCY == 1) ? ST_RD_DRIVE : ST_RD_WAIT;

    state_e                 state_q, state_d;
    logic [ADDR_BITS-1:0]   ptr_q, ptr_d;
    logic [ADDR_BITS-1:0]   idx_q, idx_d;
    logic [3:0]             cnt_q, cnt_d;
    logic                   ready_q;

    logic                   rd, wr, drive;
    logic [ADDR_BITS-1:0]   addr_idx;
    logic [1:0]             lane_we, ram_we;
    logic [15:0]            ram_wdata, ram_rdata;
    logic                   unused_addr_hi;

    assign rd       = !bus.Mem_CE && !bus.Mem_OE && bus.Mem_WE;
    assign wr       = !bus.Mem_CE && !bus.Mem_WE;
    assign addr_idx = bus.ADDR[ADDR_BITS-1:0];
    assign lane_we  = ~{bus.Mem_UB, bus.Mem_LB};
    assign unused_addr_hi = ^bus.ADDR[19:ADDR_BITS];

    // RAM is addressed by the next latched index so its registered output
    // already holds the target word on the first RD_DRIVE cycle.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        ram_we    = LANES_NONE;
        ram_wdata = Data;
        case (state_q)
            ST_INIT: begin
                ram_we    = LANES_ALL;
                ram_wdata = program_word(32'(ptr_q));
                idx_d     = ptr_q;
                ptr_d     = ptr_q + 1'b1;
                if (ptr_q == '1) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (wr) begin
                    ram_we = lane_we;
                    idx_d  = addr_idx;
                end else if (rd) begin
                    idx_d   = addr_idx;
                    cnt_d   = CNT_RELOAD;
                    state_d = RELOAD_ST;
                end
            end
            ST_RD_WAIT, ST_RD_DRIVE: begin
                if (wr) begin
                    ram_we  = lane_we;
                    idx_d   = addr_idx;
                    state_d = ST_IDLE;
                end else if (!rd) begin
                    state_d = ST_IDLE;
                end else if (addr_idx != idx_q) begin
                    idx_d   = addr_idx;
                    cnt_d   = CNT_RELOAD;
                    state_d = RELOAD_ST;
                end else if (state_q == ST_RD_WAIT) begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_d = ST_RD_DRIVE;
                    end
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= ST_INIT;
            ptr_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            ready_q <= (state_d != ST_INIT);
        end
    end

    bytelane_ram #(
        .AW (ADDR_BITS)
    ) u_ram (
        .clk_i   (Clk),
        .we_i    (ram_we),
        .addr_i  (idx_d),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

    // Drive follows live OE/CE/WE so release never waits for a clock edge
    assign drive          = (state_q == ST_RD_DRIVE) && rd;
    assign bus.Data_drive = drive;
    assign bus.Ready      = ready_q;

    assign Data[15:8] = (drive && !bus.Mem_UB) ? ram_rdata[15:8] : 8'hzz;
    assign Data[7:0]  = (drive && !bus.Mem_LB) ? ram_rdata[7:0]  : 8'hzz;

endmodule

// File: tb/tb_sram_responder.sv
// Directed bench for sram_responder: two instances (READ_LATENCY 2 and 3)
// share one stimulus stream with ADDR_BITS=4.
module tb_sram_responder;

    logic Clk = 1'b0;
    logic Reset;
    always #5 Clk = ~Clk;

    sram_responder_if bus2();
    sram_responder_if bus3();

    wire  [15:0] data2;
    wire  [15:0] data3;
    logic        tb_hi_en;
    logic        tb_lo_en;
    logic [15:0] tb_wdata;

    assign data2[15:8] = tb_hi_en ? tb_wdata[15:8] : 8'hzz;
    assign data2[7:0]  = tb_lo_en ? tb_wdata[7:0]  : 8'hzz;
    assign data3[15:8] = tb_hi_en ? tb_wdata[15:8] : 8'hzz;
    assign data3[7:0]  = tb_lo_en ? tb_wdata[7:0]  : 8'hzz;

    assign bus3.ADDR   = bus2.ADDR;
    assign bus3.Mem_CE = bus2.Mem_CE;
    assign bus3.Mem_UB = bus2.Mem_UB;
    assign bus3.Mem_LB = bus2.Mem_LB;
    assign bus3.Mem_OE = bus2.Mem_OE;
    assign bus3.Mem_WE = bus2.Mem_WE;

    sram_responder #(
        .ADDR_BITS    (4),
        .READ_LATENCY (2)
    ) dut2 (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus2),
        .Data  (data2)
    );

    sram_responder #(
        .ADDR_BITS    (4),
        .READ_LATENCY (3)
    ) dut3 (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus3),
        .Data  (data3)
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic bus_idle();
        bus2.Mem_CE = 1'b1;
        bus2.Mem_OE = 1'b1;
        bus2.Mem_WE = 1'b1;
        bus2.Mem_UB = 1'b0;
        bus2.Mem_LB = 1'b0;
        tb_hi_en    = 1'b0;
        tb_lo_en    = 1'b0;
    endtask

    // Holds a read request at addr 1 through INIT; it must never be served
    task automatic run_reset(input string tag);
        int cnt;
        Reset = 1'b1;
        tick();
        check({tag, " rdy0"}, 32'(bus2.Ready), 0);
        check({tag, " drv0"}, 32'(bus2.Data_drive), 0);
        Reset       = 1'b0;
        bus2.ADDR   = 20'd1;
        bus2.Mem_CE = 1'b0;
        bus2.Mem_OE = 1'b0;
        bus2.Mem_WE = 1'b1;
        cnt = 0;
        while (!bus2.Ready && cnt < 40) begin
            check({tag, " init nodrv"}, 32'(bus2.Data_drive), 0);
            cnt++;
            tick();
        end
        bus_idle();
        check({tag, " init cycles"}, 32'(cnt), 16);
        check({tag, " rdy3"}, 32'(bus3.Ready), 1);
        tick();
    endtask

    task automatic do_read(input logic [19:0] a, input logic ub, input logic lb,
                           input logic [15:0] exp, input string tag);
        bus2.ADDR   = a;
        bus2.Mem_UB = ub;
        bus2.Mem_LB = lb;
        bus2.Mem_WE = 1'b1;
        bus2.Mem_CE = 1'b0;
        bus2.Mem_OE = 1'b0;
        tick();
        check({tag, " wait"}, 32'(bus2.Data_drive), 0);
        tick();
        check({tag, " drv"}, 32'(bus2.Data_drive), 1);
        check({tag, " data"}, 32'(data2), 32'(exp));
        check({tag, " lat3 wait"}, 32'(bus3.Data_drive), 0);
        bus2.Mem_CE = 1'b1;
        bus2.Mem_OE = 1'b1;
        tick();
    endtask

    task automatic do_write(input logic [19:0] a, input logic ub, input logic lb,
                            input logic [15:0] d, input logic oe, input string tag);
        bus2.ADDR   = a;
        bus2.Mem_UB = ub;
        bus2.Mem_LB = lb;
        tb_wdata    = d;
        tb_hi_en    = 1'b1;
        tb_lo_en    = 1'b1;
        bus2.Mem_CE = 1'b0;
        bus2.Mem_WE = 1'b0;
        bus2.Mem_OE = oe;
        #1;
        check({tag, " nodrv"}, 32'(bus2.Data_drive), 0);
        tick();
        check({tag, " nodrv post"}, 32'(bus2.Data_drive), 0);
        bus_idle();
    endtask

    logic [15:0] prog [3] = '{16'h5020, 16'h1021, 16'h0FFE};

    initial begin
        Reset     = 1'b1;
        tb_wdata  = '0;
        bus2.ADDR = '0;
        bus_idle();

        run_reset("reset");

        for (int i = 0; i < 16; i++) begin
            do_read(20'(i), 1'b0, 1'b0, (i < 3) ? prog[i] : 16'h0000, $sformatf("rd%0d", i));
        end

        // OE release is combinational, no edge needed
        bus2.ADDR   = 20'd1;
        bus2.Mem_CE = 1'b0;
        bus2.Mem_OE = 1'b0;
        tick();
        tick();
        check("oe drv", 32'(bus2.Data_drive), 1);
        bus2.Mem_OE = 1'b1;
        #1;
        check("oe release", 32'(bus2.Data_drive), 0);
        bus_idle();
        tick();

        do_write(20'd5, 1'b0, 1'b1, 16'hABCD, 1'b1, "wr hi");
        do_write(20'd5, 1'b1, 1'b0, 16'h1234, 1'b1, "wr lo");
        do_write(20'd5, 1'b1, 1'b1, 16'hFFFF, 1'b1, "wr none");
        do_read(20'd5, 1'b0, 1'b0, 16'hAB34, "rd5");
        tb_wdata = 16'h005A;
        tb_lo_en = 1'b1;
        do_read(20'd5, 1'b0, 1'b1, 16'hAB5A, "rd5 lb");
        bus_idle();

        do_write(20'h00013, 1'b0, 1'b0, 16'hBEEF, 1'b0, "wr alias");
        do_read(20'd3, 1'b0, 1'b0, 16'hBEEF, "rd3 alias");

        // Address change during the wait restarts the full latency
        bus2.ADDR   = 20'd0;
        bus2.Mem_CE = 1'b0;
        bus2.Mem_OE = 1'b0;
        tick();
        bus2.ADDR = 20'd2;
        tick();
        check("mw lat3 e1", 32'(bus3.Data_drive), 0);
        tick();
        check("mw lat3 e2", 32'(bus3.Data_drive), 0);
        check("mw lat2 drv", 32'(bus2.Data_drive), 1);
        check("mw lat2 data", 32'(data2), 32'h0FFE);
        tick();
        check("mw lat3 drv", 32'(bus3.Data_drive), 1);
        check("mw lat3 data", 32'(data3), 32'h0FFE);
        bus_idle();
        tick();

        // Reset while driving: run_reset keeps the read request asserted
        bus2.ADDR   = 20'd5;
        bus2.Mem_CE = 1'b0;
        bus2.Mem_OE = 1'b0;
        tick();
        tick();
        check("pre-rst drv", 32'(bus2.Data_drive), 1);
        check("pre-rst data", 32'(data2), 32'hAB34);
        run_reset("midread");
        do_read(20'd5, 1'b0, 1'b0, 16'h0000, "rd5 cleared");
        do_read(20'd3, 1'b0, 1'b0, 16'h0000, "rd3 cleared");
        do_read(20'd2, 1'b0, 1'b0, 16'h0FFE, "rd2 reinit");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sram_responder.md
Name: sram_responder

Overview:
- Memory-side responder for the SLC-3 external SRAM interface: the device end of the ADDR/Data/Mem_* bus that the processor's MAR/MDR datapath initiates.
- Emulates the asynchronous SRAM as a synchronous on-chip word memory with byte lanes and configurable read wait states.
- Runs an init FSM after reset that preloads a test program.
- Used in simulation and on-board in place of the physical SRAM.

Parameters:
ADDR_BITS, 10, number of word-address bits implemented; depth = 2**ADDR_BITS; ADDR bits above are ignored (aliasing/wrap).
READ_LATENCY, 2, edges from first sampled read request to Data driven; legal range 1..15.

Ports:
Clk  input  1  system clock, all state on rising edge
Reset  input  1  synchronous, active-high; forces INIT
ADDR  input  20  word address from MAR
Data  inout  16  shared data bus; driven only during a valid read
Mem_CE  input  1  chip enable, active-low
Mem_UB  input  1  upper-byte lane enable, active-low
Mem_LB  input  1  lower-byte lane enable, active-low
Mem_OE  input  1  output enable (read), active-low
Mem_WE  input  1  write enable, active-low
Ready  output  1  high once init is complete and requests are accepted
Data_drive  output  1  high in any cycle this block drives Data (debug/checker)

Behaviour:
- Request decode: rd = !CE & !OE & WE; wr = !CE & !WE. wr wins if OE is also low. Word index = ADDR[ADDR_BITS-1:0].
- States: INIT, IDLE, RD_WAIT, RD_DRIVE.
- Reset: state=INIT, init_ptr=0, Ready=0, Data_drive=0, Data=Z. Reset mid-read releases Data from the first edge at which Reset is sampled.
- INIT: one word per cycle, mem[init_ptr] = PROGRAM[init_ptr] if init_ptr < PROG_LEN, else 16'h0000. init_ptr increments. After writing index 2**ADDR_BITS-1 -> IDLE. INIT takes exactly 2**ADDR_BITS cycles. Ready=1 is registered, first high in the first IDLE cycle. Bus requests during INIT are ignored and never drive Data.
- IDLE:
  - wr sampled: commit that edge. mem[idx][15:8] = Data[15:8] if !UB; mem[idx][7:0] = Data[7:0] if !LB. Stay IDLE. Both lanes high -> no change.
  - rd sampled: latch idx, cnt = READ_LATENCY-1; go to RD_DRIVE if cnt==0, else RD_WAIT.
- RD_WAIT:
  - Decrement cnt each edge; at 0 -> RD_DRIVE.
  - rd dropped -> IDLE.
  - wr sampled -> commit as in IDLE, then IDLE.
  - ADDR index change -> relatch, reload cnt (restart wait).
- RD_DRIVE:
  - Data_drive = (state==RD_DRIVE) & rd, evaluated combinationally on live inputs, so release is immediate when the processor deasserts OE/CE or asserts WE (no contention window).
  - Driven value is mem[latched idx] registered. Upper byte = Z if UB high; lower byte = Z if LB high.
  - Address change -> RD_WAIT with reload. rd dropped -> IDLE. wr -> commit, IDLE.
- Data is never driven in INIT, IDLE or RD_WAIT.
- Back-to-back reads: each new address pays the full READ_LATENCY.
- Read-after-write to the same address returns the new data.

Decomposition:
- Package sram_responder_pkg holds:
  - state enum (INIT, IDLE, RD_WAIT, RD_DRIVE)
  - PROG_LEN
  - PROGRAM constant array of 16-bit words (default: the team's I/O test program)
  - lane helper constants
- One sub-module: bytelane_ram. Single-port synchronous RAM, two byte write enables, registered read.
- The FSM, counter, init pointer and tristate control stay in sram_responder.

Test Plan:
- Init: Reset 1 cycle, ADDR_BITS=4, PROG_LEN=3, PROGRAM={16'h5020,16'h1021,16'h0FFE} -> Ready low exactly 16 cycles, then high. Reads of 0..2 return the program. Read of 3..15 returns 16'h0000.
- Read latency: READ_LATENCY=2, ADDR=1, CE=OE=0 -> Data Z for 1 cycle after sampling, 16'h1021 from the 2nd edge on. OE high -> Data Z in the same cycle, Data_drive=0.
- Byte writes: write 16'hABCD to addr 5 with UB=0, LB=1, then 16'h1234 with UB=1, LB=0 -> read returns 16'hAB34. Read with LB=1 -> Data = {8'hAB,8'hZZ}.
- Aliasing/priority: write 16'hBEEF at ADDR=20'h00013 (ADDR_BITS=4) with OE also low -> write taken, no drive. Read ADDR=3 -> 16'hBEEF.
- Address change mid-wait: READ_LATENCY=3, read addr 0, change to addr 2 after 1 cycle -> Data first driven 3 edges after the change, value 16'h0FFE.
- Reset mid-read: Reset in RD_DRIVE -> Data Z, Ready 0 at the next edge. Init reruns and clears addr 5 back to 16'h0000.
